// File: rtl/novacore_cfg_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : novacore_cfg_loader_if
// Brief    : Record stream handshake plus fabric configuration bus bundle
//            for the NovaCORE configuration loader.
// Revision : 1.0 - initial release
// ============================================================================
interface novacore_cfg_loader_if #(
  parameter int DATA_W = 18,
  parameter int UID_W  = 4,
  parameter int DIM_W  = 2
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mode;
  logic [DATA_W-1:0] c_bus;
  logic [UID_W-1:0]  c_uid;
  logic              c_clk;
  logic [DIM_W-1:0]  c_dimension;
  logic              c_dimswitch;
  logic              busy;
  logic              err;

  // Loader side: consumes the record stream, drives the fabric port
  modport master (
    input  in_data, in_valid,
    output in_ready, mode, c_bus, c_uid, c_clk, c_dimension, c_dimswitch,
           busy, err
  );

  // Environment side: produces the record stream, observes the fabric port
  modport slave (
    output in_data, in_valid,
    input  in_ready, mode, c_bus, c_uid, c_clk, c_dimension, c_dimswitch,
           busy, err
  );
endinterface
`default_nettype wire

// File: rtl/novacore_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : novacore_cfg_loader
// Brief    : Takes header/payload configuration records over valid/ready and
//            serialises each payload word onto the NovaCORE configuration
//            port with a programmable setup/high/hold strobe on c_clk.
// Revision : 1.0 - initial release
// ============================================================================
module novacore_cfg_loader #(
  parameter int DATA_W    = 18,
  parameter int UID_W     = 4,
  parameter int DIM_W     = 2,
  parameter int SETUP_CYC = 2,
  parameter int HI_CYC    = 2,
  parameter int HOLD_CYC  = 1
) (
  input  wire                   clk,
  input  wire                   rst_n,
  novacore_cfg_loader_if.master bus
);

  localparam int TMR_W = 8;
  localparam logic [TMR_W-1:0] c_tmr_one   = TMR_W'(1);
  localparam logic [TMR_W-1:0] c_setup_last = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] c_hi_last    = TMR_W'(HI_CYC - 1);
  localparam logic [TMR_W-1:0] c_hold_last  = TMR_W'(HOLD_CYC - 1);

  localparam logic [1:0] c_op_cfg     = 2'b00;
  localparam logic [1:0] c_op_end     = 2'b01;
  localparam logic [1:0] c_op_restart = 2'b10;
  localparam logic [1:0] c_op_bad     = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAYLOAD = 3'd1,
    ST_SETUP   = 3'd2,
    ST_HIGH    = 3'd3,
    ST_HOLD    = 3'd4,
    ST_RUN     = 3'd5
  } state_t;

  state_t             state_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [7:0]         count_q;
  logic               in_ready_q;
  logic               mode_q;
  logic [DATA_W-1:0]  c_bus_q;
  logic [UID_W-1:0]   c_uid_q;
  logic               c_clk_q;
  logic [DIM_W-1:0]   c_dim_q;
  logic               c_dsw_q;
  logic               busy_q;
  logic               err_q;

  // Header field decode; only meaningful in the header-accepting states
  logic               w_accept;
  logic [1:0]         w_opcode;
  logic [7:0]         w_hdr_cnt;
  logic               w_hdr_dsw;
  logic [DIM_W-1:0]   w_hdr_dim;
  logic [UID_W-1:0]   w_hdr_uid;

  assign w_accept  = bus.in_valid & in_ready_q;
  assign w_opcode  = bus.in_data[17:16];
  assign w_hdr_cnt = bus.in_data[15:8];
  assign w_hdr_dsw = bus.in_data[6];
  assign w_hdr_dim = DIM_W'(bus.in_data[5:4]);
  assign w_hdr_uid = UID_W'(bus.in_data[3:0]);

  // Record sequencer: header decode, payload capture and strobe timing.
  // c_clk follows the HIGH state one cycle late, so the strobe rises
  // SETUP_CYC+1 cycles after a word is taken and falls HOLD_CYC cycles
  // before the next word can land on c_bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      mode_q     <= 1'b1;
      c_bus_q    <= '0;
      c_uid_q    <= '0;
      c_clk_q    <= 1'b0;
      c_dim_q    <= '0;
      c_dsw_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      c_clk_q <= (state_q == ST_HIGH);
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (w_accept) begin
            case (w_opcode)
              c_op_cfg: begin
                c_uid_q <= w_hdr_uid;
                c_dim_q <= w_hdr_dim;
                c_dsw_q <= w_hdr_dsw;
                count_q <= w_hdr_cnt;
                if (w_hdr_cnt != 8'd0) begin
                  state_q <= ST_PAYLOAD;
                  busy_q  <= 1'b1;
                end
              end
              c_op_end: begin
                mode_q  <= 1'b0;
                state_q <= ST_RUN;
              end
              c_op_restart: mode_q <= 1'b1;
              default:      err_q  <= 1'b1;
            endcase
          end
        end
        ST_PAYLOAD: begin
          if (w_accept) begin
            c_bus_q    <= bus.in_data;
            in_ready_q <= 1'b0;
            tmr_q      <= '0;
            state_q    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_q == c_setup_last) begin
            tmr_q   <= '0;
            state_q <= ST_HIGH;
          end else begin
            tmr_q <= tmr_q + c_tmr_one;
          end
        end
        ST_HIGH: begin
          if (tmr_q == c_hi_last) begin
            tmr_q   <= '0;
            state_q <= ST_HOLD;
          end else begin
            tmr_q <= tmr_q + c_tmr_one;
          end
        end
        ST_HOLD: begin
          if (tmr_q == c_hold_last) begin
            tmr_q      <= '0;
            count_q    <= count_q - 8'd1;
            in_ready_q <= 1'b1;
            if (count_q == 8'd1) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_PAYLOAD;
            end
          end else begin
            tmr_q <= tmr_q + c_tmr_one;
          end
        end
        ST_RUN: begin
          in_ready_q <= 1'b1;
          if (w_accept) begin
            if (w_opcode == c_op_restart) begin
              mode_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else if (w_opcode == c_op_bad) begin
              err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.mode        = mode_q;
  assign bus.c_bus       = c_bus_q;
  assign bus.c_uid       = c_uid_q;
  assign bus.c_clk       = c_clk_q;
  assign bus.c_dimension = c_dim_q;
  assign bus.c_dimswitch = c_dsw_q;
  assign bus.busy        = busy_q;
  assign bus.err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_novacore_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_novacore_cfg_loader
// Brief    : Directed self-checking bench for novacore_cfg_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_novacore_cfg_loader;

  localparam int DATA_W    = 18;
  localparam int UID_W     = 4;
  localparam int DIM_W     = 2;
  localparam int SETUP_CYC = 2;
  localparam int HI_CYC    = 2;
  localparam int HOLD_CYC  = 1;
  localparam int VEC_W     = DATA_W + UID_W + DIM_W + 1;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;

  novacore_cfg_loader_if #(.DATA_W(DATA_W), .UID_W(UID_W), .DIM_W(DIM_W)) intf ();

  novacore_cfg_loader #(
    .DATA_W(DATA_W), .UID_W(UID_W), .DIM_W(DIM_W),
    .SETUP_CYC(SETUP_CYC), .HI_CYC(HI_CYC), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (intf.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Fabric-side observer: strobe rises, high width, and stability of the
  // c_bus/c_uid/c_dimension/c_dimswitch bundle around each strobe.
  logic [VEC_W-1:0] w_vec;
  logic [VEC_W-1:0] mon_prev_vec;
  logic             mon_prev_clk;
  int               mon_stab, mon_low, mon_hi;
  int               rise_cnt, viol_cnt, hi_bad;
  logic [DATA_W-1:0] rise_bus[$];
  int               rise_cyc[$];

  assign w_vec = {intf.c_bus, intf.c_uid, intf.c_dimension, intf.c_dimswitch};

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev_vec = w_vec;
      mon_prev_clk = 1'b0;
      mon_stab     = 100;
      mon_low      = 100;
      mon_hi       = 0;
    end else begin
      if (w_vec !== mon_prev_vec) begin
        if (mon_prev_clk || intf.c_clk || mon_low < HOLD_CYC) viol_cnt++;
        mon_stab = 0;
      end
      if (intf.c_clk && !mon_prev_clk) begin
        rise_cnt++;
        rise_bus.push_back(intf.c_bus);
        rise_cyc.push_back(cyc);
        if (mon_stab < SETUP_CYC) viol_cnt++;
        mon_hi = 0;
      end
      if (intf.c_clk) mon_hi++;
      if (!intf.c_clk && mon_prev_clk && mon_hi != HI_CYC) hi_bad++;
      mon_low      = intf.c_clk ? 0 : mon_low + 1;
      mon_stab     = mon_stab + 1;
      mon_prev_clk = intf.c_clk;
      mon_prev_vec = w_vec;
    end
  end

  // Present one word with in_valid held high until it is taken; returns the
  // cycle index of the accepting edge. Called and returns at a negedge.
  task automatic send_word(input logic [DATA_W-1:0] d, output int acc);
    int n;
    n = 0;
    intf.in_data  = d;
    intf.in_valid = 1'b1;
    while (intf.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b required 1 within 100 cycles", intf.in_ready);
    end
    acc = cyc + 1;
    @(negedge clk);
    intf.in_valid = 1'b0;
  endtask

  // Same, but in_valid toggles randomly and in_data is junk while invalid
  task automatic send_word_rand(input logic [DATA_W-1:0] d);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      if ($urandom_range(0, 1) == 1) begin
        intf.in_valid = 1'b1;
        intf.in_data  = d;
        done          = (intf.in_ready === 1'b1);
      end else begin
        intf.in_valid = 1'b0;
        intf.in_data  = DATA_W'($urandom);
      end
      @(negedge clk);
      n++;
    end
    intf.in_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL send_rand_timeout: word %h not taken in 200 cycles", d);
    end
  endtask

  task automatic wait_busy_low(output int drop);
    int n;
    n = 0;
    while (intf.busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 300) begin
      n_fail++;
      $display("FAIL busy_timeout: busy=%b required 0 within 300 cycles", intf.busy);
    end
    drop = cyc;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    intf.in_valid = 1'b0;
    intf.in_data  = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (intf.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", intf.in_ready); end
    n_checks++; if (intf.mode !== 1'b1) begin n_fail++; $display("FAIL rst_mode: got %b want 1", intf.mode); end
    n_checks++; if (intf.c_clk !== 1'b0) begin n_fail++; $display("FAIL rst_c_clk: got %b want 0", intf.c_clk); end
    n_checks++; if (intf.c_bus !== 18'h0) begin n_fail++; $display("FAIL rst_c_bus: got %h want 0", intf.c_bus); end
    n_checks++; if (intf.c_uid !== 4'h0) begin n_fail++; $display("FAIL rst_c_uid: got %h want 0", intf.c_uid); end
    n_checks++; if (intf.c_dimension !== 2'h0) begin n_fail++; $display("FAIL rst_c_dim: got %h want 0", intf.c_dimension); end
    n_checks++; if (intf.c_dimswitch !== 1'b0) begin n_fail++; $display("FAIL rst_c_dsw: got %b want 0", intf.c_dimswitch); end
    n_checks++; if (intf.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", intf.busy); end
    n_checks++; if (intf.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", intf.err); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (intf.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b want 1", intf.in_ready); end
  endtask

  task automatic test_cfg_two_words();
    int a0, a1, a2, drop, rb, vb, hb;
    rb = rise_cnt; vb = viol_cnt; hb = hi_bad;
    send_word(18'h00203, a0);
    n_checks++; if (intf.c_uid !== 4'h3) begin n_fail++; $display("FAIL cfg2_uid: got %h want 3", intf.c_uid); end
    n_checks++; if (intf.busy !== 1'b1) begin n_fail++; $display("FAIL cfg2_busy: got %b want 1", intf.busy); end
    n_checks++; if (intf.c_bus !== 18'h0) begin n_fail++; $display("FAIL cfg2_hdr_on_bus: got %h want 0", intf.c_bus); end
    send_word(18'h15555, a1);
    send_word(18'h2AAAA, a2);
    wait_busy_low(drop);
    n_checks++; if (rise_cnt - rb !== 2) begin n_fail++; $display("FAIL cfg2_strobes: got %0d want 2", rise_cnt - rb); end
    if (rise_cnt - rb >= 2) begin
      n_checks++; if (rise_bus[rb] !== 18'h15555) begin n_fail++; $display("FAIL cfg2_bus0: got %h want 15555", rise_bus[rb]); end
      n_checks++; if (rise_bus[rb+1] !== 18'h2AAAA) begin n_fail++; $display("FAIL cfg2_bus1: got %h want 2aaaa", rise_bus[rb+1]); end
      n_checks++; if (rise_cyc[rb] - a1 !== 3) begin n_fail++; $display("FAIL cfg2_lat0: got %0d want 3", rise_cyc[rb] - a1); end
      n_checks++; if (rise_cyc[rb+1] - a2 !== 3) begin n_fail++; $display("FAIL cfg2_lat1: got %0d want 3", rise_cyc[rb+1] - a2); end
    end
    n_checks++; if (a2 - a1 !== 6) begin n_fail++; $display("FAIL cfg2_period: got %0d want 6", a2 - a1); end
    n_checks++; if (drop - a2 !== 5) begin n_fail++; $display("FAIL cfg2_busy_drop: got %0d want 5", drop - a2); end
    n_checks++; if (hi_bad - hb !== 0) begin n_fail++; $display("FAIL cfg2_hi_width: got %0d bad pulses want 0", hi_bad - hb); end
    n_checks++; if (viol_cnt - vb !== 0) begin n_fail++; $display("FAIL cfg2_stability: got %0d violations want 0", viol_cnt - vb); end
  endtask

  task automatic test_cfg_zero();
    int a, rb;
    rb = rise_cnt;
    send_word(18'h00035, a);
    n_checks++; if (intf.c_uid !== 4'h5) begin n_fail++; $display("FAIL cfg0_uid: got %h want 5", intf.c_uid); end
    n_checks++; if (intf.c_dimension !== 2'h3) begin n_fail++; $display("FAIL cfg0_dim: got %h want 3", intf.c_dimension); end
    n_checks++; if (intf.busy !== 1'b0) begin n_fail++; $display("FAIL cfg0_busy: got %b want 0", intf.busy); end
    repeat (8) @(negedge clk);
    n_checks++; if (rise_cnt - rb !== 0) begin n_fail++; $display("FAIL cfg0_strobes: got %0d want 0", rise_cnt - rb); end
    n_checks++; if (intf.in_ready !== 1'b1) begin n_fail++; $display("FAIL cfg0_ready: got %b want 1", intf.in_ready); end
  endtask

  task automatic test_end_run();
    int a, rb;
    rb = rise_cnt;
    send_word(18'h10000, a);
    n_checks++; if (intf.mode !== 1'b0) begin n_fail++; $display("FAIL end_mode: got %b want 0", intf.mode); end
    send_word(18'h00101, a);
    repeat (8) @(negedge clk);
    n_checks++; if (rise_cnt - rb !== 0) begin n_fail++; $display("FAIL run_strobes: got %0d want 0", rise_cnt - rb); end
    n_checks++; if (intf.c_uid !== 4'h5) begin n_fail++; $display("FAIL run_uid: got %h want 5", intf.c_uid); end
    n_checks++; if (intf.mode !== 1'b0) begin n_fail++; $display("FAIL run_mode: got %b want 0", intf.mode); end
    n_checks++; if (intf.busy !== 1'b0) begin n_fail++; $display("FAIL run_busy: got %b want 0", intf.busy); end
  endtask

  task automatic test_restart();
    int a;
    send_word(18'h20000, a);
    n_checks++; if (intf.mode !== 1'b1) begin n_fail++; $display("FAIL restart_mode: got %b want 1", intf.mode); end
    // A CFG header is only honoured in IDLE, so a uid update proves the state
    send_word(18'h00012, a);
    n_checks++; if (intf.c_uid !== 4'h2) begin n_fail++; $display("FAIL restart_idle_uid: got %h want 2", intf.c_uid); end
    n_checks++; if (intf.c_dimension !== 2'h1) begin n_fail++; $display("FAIL restart_idle_dim: got %h want 1", intf.c_dimension); end
  endtask

  task automatic test_illegal();
    int a, drop, rb;
    send_word(18'h30000, a);
    n_checks++; if (intf.err !== 1'b1) begin n_fail++; $display("FAIL ill_err: got %b want 1", intf.err); end
    n_checks++; if (intf.busy !== 1'b0) begin n_fail++; $display("FAIL ill_busy: got %b want 0", intf.busy); end
    rb = rise_cnt;
    send_word(18'h00101, a);
    send_word(18'h00001, a);
    wait_busy_low(drop);
    n_checks++; if (rise_cnt - rb !== 1) begin n_fail++; $display("FAIL ill_strobes: got %0d want 1", rise_cnt - rb); end
    if (rise_cnt - rb >= 1) begin
      n_checks++; if (rise_bus[rb] !== 18'h00001) begin n_fail++; $display("FAIL ill_bus: got %h want 00001", rise_bus[rb]); end
    end
    n_checks++; if (intf.c_uid !== 4'h1) begin n_fail++; $display("FAIL ill_uid: got %h want 1", intf.c_uid); end
    n_checks++; if (intf.err !== 1'b1) begin n_fail++; $display("FAIL ill_err_sticky: got %b want 1", intf.err); end
  endtask

  task automatic test_random_valid();
    int drop, rb, vb, hb;
    rb = rise_cnt; vb = viol_cnt; hb = hi_bad;
    send_word_rand(18'h00301);
    send_word_rand(18'h00001);
    send_word_rand(18'h00002);
    send_word_rand(18'h00003);
    wait_busy_low(drop);
    n_checks++; if (rise_cnt - rb !== 3) begin n_fail++; $display("FAIL rnd_strobes: got %0d want 3", rise_cnt - rb); end
    if (rise_cnt - rb >= 3) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (rise_bus[rb+i] !== DATA_W'(i + 1)) begin
          n_fail++;
          $display("FAIL rnd_bus%0d: got %h want %h", i, rise_bus[rb+i], DATA_W'(i + 1));
        end
      end
    end
    n_checks++; if (viol_cnt - vb !== 0) begin n_fail++; $display("FAIL rnd_stability: got %0d violations want 0", viol_cnt - vb); end
    n_checks++; if (hi_bad - hb !== 0) begin n_fail++; $display("FAIL rnd_hi_width: got %0d bad pulses want 0", hi_bad - hb); end
    n_checks++; if (intf.err !== 1'b1) begin n_fail++; $display("FAIL rnd_err_sticky: got %b want 1", intf.err); end
  endtask

  task automatic test_reset_mid();
    int a, a1, n, drop, rb;
    send_word(18'h00201, a);
    send_word(18'h3FFFF, a);
    n = 0;
    while (intf.c_clk !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++; if (intf.c_clk !== 1'b1) begin n_fail++; $display("FAIL mid_no_strobe: c_clk=%b want 1", intf.c_clk); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (intf.c_clk !== 1'b0) begin n_fail++; $display("FAIL mid_c_clk: got %b want 0", intf.c_clk); end
    n_checks++; if (intf.mode !== 1'b1) begin n_fail++; $display("FAIL mid_mode: got %b want 1", intf.mode); end
    n_checks++; if (intf.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", intf.busy); end
    n_checks++; if (intf.err !== 1'b0) begin n_fail++; $display("FAIL mid_err: got %b want 0", intf.err); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rb = rise_cnt;
    send_word(18'h00101, a);
    send_word(18'h00001, a1);
    wait_busy_low(drop);
    n_checks++; if (rise_cnt - rb !== 1) begin n_fail++; $display("FAIL post_rst_strobes: got %0d want 1", rise_cnt - rb); end
    if (rise_cnt - rb >= 1) begin
      n_checks++; if (rise_bus[rb] !== 18'h00001) begin n_fail++; $display("FAIL post_rst_bus: got %h want 00001", rise_bus[rb]); end
      n_checks++; if (rise_cyc[rb] - a1 !== 3) begin n_fail++; $display("FAIL post_rst_lat: got %0d want 3", rise_cyc[rb] - a1); end
    end
    n_checks++; if (intf.c_uid !== 4'h1) begin n_fail++; $display("FAIL post_rst_uid: got %h want 1", intf.c_uid); end
  endtask

  initial begin
    rst_n         = 1'b0;
    intf.in_valid = 1'b0;
    intf.in_data  = '0;
    @(negedge clk);
    test_reset();
    test_cfg_two_words();
    test_cfg_zero();
    test_end_run();
    test_restart();
    test_illegal();
    test_random_valid();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
`default_nettype wire
